// File: rtl/sp_writeback_ctrl.sv
// sp_writeback_ctrl
// Write-back sequencer between the matrix-multiply datapath and the scratchpad.
// Latches one result matrix on start and writes it element by element into the
// selected SP target. In accumulate mode each element is first read from the
// bias target, added (signed, wrapping) to the result element, and the sum is
// written back. Overflow of any such add is recorded in a sticky flag.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              request, sampled only while idle
//   mode_i               0 = overwrite, 1 = accumulate with bias
//   write_target_i       destination SP target (latched at start)
//   bias_target_i        bias SP target (latched at start)
//   res_data_i           flattened result matrix, element k at [k*BUS_WIDTH +: BUS_WIDTH]
//   sp_rdata_i           combinational SP read data
//   sp_we_o / sp_addr_o / sp_wtarget_o / sp_rtarget_o / sp_wdata_o   SP controls
//   busy_o               high while not idle
//   done_o               one-cycle completion pulse
//   overflow_o           sticky signed-add overflow, cleared by the next start
module sp_writeback_ctrl #(
    parameter  int DATA_WIDTH = 32,
    parameter  int BUS_WIDTH  = 64,
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int N          = MAX_DIM * MAX_DIM,
    localparam int AW         = 2 * $clog2(MAX_DIM)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   mode_i,
    input  logic [1:0]             write_target_i,
    input  logic [1:0]             bias_target_i,
    input  logic [N*BUS_WIDTH-1:0] res_data_i,
    input  logic [BUS_WIDTH-1:0]   sp_rdata_i,
    output logic                   sp_we_o,
    output logic [AW-1:0]          sp_addr_o,
    output logic [1:0]             sp_wtarget_o,
    output logic [1:0]             sp_rtarget_o,
    output logic [BUS_WIDTH-1:0]   sp_wdata_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   overflow_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic                 mode_q, mode_d;
    logic [1:0]           wtgt_q, wtgt_d;
    logic [1:0]           btgt_q, btgt_d;
    logic [BUS_WIDTH-1:0] elem_q [N];
    logic [BUS_WIDTH-1:0] elem_d [N];
    logic [BUS_WIDTH-1:0] sum_q, sum_d;
    logic                 ovf_q, ovf_d;

    logic [BUS_WIDTH-1:0] cur_elem;
    logic [BUS_WIDTH-1:0] add_res;
    logic                 add_ovf;

    assign cur_elem = elem_q[idx_q];
    assign add_res  = sp_rdata_i + cur_elem;
    // Signed overflow: operands agree in sign, result does not.
    assign add_ovf  = (sp_rdata_i[BUS_WIDTH-1] == cur_elem[BUS_WIDTH-1]) &&
                      (add_res[BUS_WIDTH-1] != sp_rdata_i[BUS_WIDTH-1]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        wtgt_d  = wtgt_q;
        btgt_d  = btgt_q;
        elem_d  = elem_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d = mode_i;
                    wtgt_d = write_target_i;
                    btgt_d = bias_target_i;
                    idx_d  = '0;
                    ovf_d  = 1'b0;
                    for (int unsigned k = 0; k < N; k++) begin
                        elem_d[k] = res_data_i[k*BUS_WIDTH +: BUS_WIDTH];
                    end
                    state_d = mode_i ? S_RD : S_WR;
                end
            end
            S_RD: begin
                sum_d = add_res;
                if (add_ovf) begin
                    ovf_d = 1'b1;
                end
                state_d = S_WR;
            end
            S_WR: begin
                if (idx_q == AW'(N - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = mode_q ? S_RD : S_WR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            wtgt_q  <= '0;
            btgt_q  <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            for (int unsigned k = 0; k < N; k++) begin
                elem_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            wtgt_q  <= wtgt_d;
            btgt_q  <= btgt_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            elem_q  <= elem_d;
        end
    end

    // All outputs are decoded directly from flops, so they clear the moment
    // reset asserts.
    assign sp_we_o      = (state_q == S_WR);
    assign sp_addr_o    = idx_q;
    assign sp_wtarget_o = wtgt_q;
    assign sp_rtarget_o = btgt_q;
    assign sp_wdata_o   = sp_we_o ? (mode_q ? sum_q : cur_elem) : '0;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign overflow_o   = ovf_q;

endmodule
